gpio_bank: RTL and testbench

- Parametrised memory-mapped GPIO peripheral on the core's data bus, selected by address[31]=1. Successor to the fixed 8-bit GPIO block.
- Adds:
  - width up to 32 bits
  - configurable input synchroniser depth
  - atomic set/clear of output bits
  - per-pin edge-detect interrupts with sticky, write-1-to-clear status
  - a registered one-cycle bus response

---
 rtl/gpio_bank.sv | 162 ++++++++++++++++
 tb/tb_gpio_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with synchronised pad inputs, atomic
// set/clear of outputs and per-pin edge interrupts with sticky W1C status.
module gpio_bank #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] DIR_RESET   = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      address,
   input  logic [31:0]      write_data,
   output logic [31:0]      read_data,
   output logic             response,
   input  logic [WIDTH-1:0] gpios_in,
   output logic [WIDTH-1:0] gpios_out,
   output logic [WIDTH-1:0] direction,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DATA_IN  = 3'd0,
      REG_DATA_OUT = 3'd1,
      REG_DIR      = 3'd2,
      REG_IRQ_EN   = 3'd3,
      REG_IRQ_POL  = 3'd4,
      REG_IRQ_STAT = 3'd5,
      REG_OUT_SET  = 3'd6,
      REG_OUT_CLR  = 3'd7
   } reg_sel_e;

   reg_sel_e                          sel_s;
   logic [WIDTH-1:0]                  wdata_s;
   logic                              wr_s;
   logic                              rd_s;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   logic [WIDTH-1:0]                  sync_s;
   logic [WIDTH-1:0]                  prev_r;
   logic [WIDTH-1:0]                  out_r;
   logic [WIDTH-1:0]                  dir_r;
   logic [WIDTH-1:0]                  en_r;
   logic [WIDTH-1:0]                  pol_r;
   logic [WIDTH-1:0]                  stat_r;
   logic [WIDTH-1:0]                  out_nxt_s;
   logic [WIDTH-1:0]                  dir_nxt_s;
   logic [WIDTH-1:0]                  en_nxt_s;
   logic [WIDTH-1:0]                  pol_nxt_s;
   logic [WIDTH-1:0]                  stat_nxt_s;
   logic [WIDTH-1:0]                  w1c_s;
   logic [WIDTH-1:0]                  event_s;
   logic [WIDTH-1:0]                  rmux_s;
   logic [31:0]                       rdata_r;
   logic                              resp_r;
   logic                              unused_s;

   // Pins driven as outputs never record events; pol selects rising (1) or falling (0).
   function automatic logic [WIDTH-1:0] edge_events(
      input logic [WIDTH-1:0] sync,
      input logic [WIDTH-1:0] prev,
      input logic [WIDTH-1:0] pol,
      input logic [WIDTH-1:0] dir
   );
      return ((sync & ~prev & pol) | (~sync & prev & ~pol)) & ~dir;
   endfunction

   assign sel_s    = reg_sel_e'(address[4:2]);
   assign wdata_s  = write_data[WIDTH-1:0];
   assign wr_s     = write;
   assign rd_s     = read & ~write;
   assign sync_s   = sync_r[SYNC_STAGES-1];
   assign event_s  = edge_events(sync_s, prev_r, pol_r, dir_r);
   assign unused_s = ^{address[31:5], address[1:0], write_data};

   // Register-file next state; a new event outranks a W1C on the same bit.
   always_comb begin
      out_nxt_s = out_r;
      dir_nxt_s = dir_r;
      en_nxt_s  = en_r;
      pol_nxt_s = pol_r;
      w1c_s     = '0;
      if (wr_s) begin
         case (sel_s)
            REG_DATA_OUT: out_nxt_s = wdata_s;
            REG_DIR:      dir_nxt_s = wdata_s;
            REG_IRQ_EN:   en_nxt_s  = wdata_s;
            REG_IRQ_POL:  pol_nxt_s = wdata_s;
            REG_IRQ_STAT: w1c_s     = wdata_s;
            REG_OUT_SET:  out_nxt_s = out_r | wdata_s;
            REG_OUT_CLR:  out_nxt_s = out_r & ~wdata_s;
            default:      out_nxt_s = out_r;
         endcase
      end else begin
         out_nxt_s = out_r;
      end
      stat_nxt_s = (stat_r & ~w1c_s) | event_s;
   end

   // Read multiplexer; write-only and unmapped views read as zero.
   always_comb begin
      rmux_s = '0;
      case (sel_s)
         REG_DATA_IN:  rmux_s = sync_s;
         REG_DATA_OUT: rmux_s = out_r;
         REG_DIR:      rmux_s = dir_r;
         REG_IRQ_EN:   rmux_s = en_r;
         REG_IRQ_POL:  rmux_s = pol_r;
         REG_IRQ_STAT: rmux_s = stat_r;
         default:      rmux_s = '0;
      endcase
   end

   // Pad synchroniser chain and one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
         prev_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], gpios_in};
         prev_r <= sync_s;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r  <= '0;
         dir_r  <= DIR_RESET[WIDTH-1:0];
         en_r   <= '0;
         pol_r  <= '0;
         stat_r <= '0;
      end else begin
         out_r  <= out_nxt_s;
         dir_r  <= dir_nxt_s;
         en_r   <= en_nxt_s;
         pol_r  <= pol_nxt_s;
         stat_r <= stat_nxt_s;
      end
   end

   // Bus response: read data held until the next pure read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_r <= 32'h0000_0000;
         resp_r  <= 1'b0;
      end else begin
         resp_r <= read | write;
         if (rd_s) begin
            rdata_r <= 32'(rmux_s);
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   assign read_data = rdata_r;
   assign response  = resp_r;
   assign gpios_out = out_r;
   assign direction = dir_r;
   assign irq       = |(stat_r & en_r);

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank (WIDTH=8, SYNC_STAGES=2): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_gpio_bank;
   localparam int W = 8;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        response;
   logic [7:0]  gpios_in;
   logic [7:0]  gpios_out;
   logic [7:0]  direction;
   logic        irq;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DIR_RESET(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
      .write_data(write_data), .read_data(read_data), .response(response),
      .gpios_in(gpios_in), .gpios_out(gpios_out), .direction(direction), .irq(irq)
   );

   // Behavioural model: registers by name, pad history as "value seen k edges ago".
   logic [7:0]  m_out, m_dir, m_en, m_pol, m_stat;
   logic [31:0] m_rdata;
   logic        m_resp;
   logic [7:0]  pad_seen [0:3];

   function automatic logic [7:0] m_events(input logic [7:0] sync, input logic [7:0] prev,
                                           input logic [7:0] pol, input logic [7:0] dir);
      logic [7:0] ev;
      ev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (!dir[i] && (sync[i] != prev[i]) && (sync[i] == pol[i])) ev[i] = 1'b1;
      end
      return ev;
   endfunction

   function automatic logic [7:0] m_read(input logic [2:0] idx);
      case (idx)
         3'd0:    return pad_seen[S-1];
         3'd1:    return m_out;
         3'd2:    return m_dir;
         3'd3:    return m_en;
         3'd4:    return m_pol;
         3'd5:    return m_stat;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_out <= 8'h00; m_dir <= 8'h00; m_en <= 8'h00; m_pol <= 8'h00; m_stat <= 8'h00;
         m_rdata <= 32'h0; m_resp <= 1'b0;
         for (int k = 0; k < 4; k++) pad_seen[k] <= 8'h00;
      end else begin
         for (int k = 1; k < 4; k++) pad_seen[k] <= pad_seen[k-1];
         pad_seen[0] <= gpios_in;
         m_resp <= read | write;
         m_stat <= (m_stat & ~((write && address[4:2] == 3'd5) ? write_data[7:0] : 8'h00))
                   | m_events(pad_seen[S-1], pad_seen[S], m_pol, m_dir);
         if (write) begin
            if (address[4:2] == 3'd1) m_out <= write_data[7:0];
            if (address[4:2] == 3'd2) m_dir <= write_data[7:0];
            if (address[4:2] == 3'd3) m_en  <= write_data[7:0];
            if (address[4:2] == 3'd4) m_pol <= write_data[7:0];
            if (address[4:2] == 3'd6) m_out <= m_out | write_data[7:0];
            if (address[4:2] == 3'd7) m_out <= m_out & ~write_data[7:0];
         end else if (read) begin
            m_rdata <= {24'h000000, m_read(address[4:2])};
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("model gpios_out", {24'h0, gpios_out}, {24'h0, m_out});
         check("model direction", {24'h0, direction}, {24'h0, m_dir});
         check("model irq", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
         check("model response", {31'h0, response}, {31'h0, m_resp});
         check("model read_data", read_data, m_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addr_of(input logic [2:0] idx);
      return {1'b1, 26'h0, idx, 2'b00};
   endfunction

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
      address = addr_of(idx); write_data = d; write = 1'b1;
      tick();
      write = 1'b0;
      check("write response", {31'h0, response}, 32'd1);
      tick();
      check("write response end", {31'h0, response}, 32'd0);
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
      address = addr_of(idx); read = 1'b1;
      tick();
      read = 1'b0;
      check("read response", {31'h0, response}, 32'd1);
      d = read_data;
      tick();
   endtask

   initial begin
      logic [31:0] d;
      reset = 1'b1; read = 1'b0; write = 1'b0; address = 32'h0; write_data = 32'h0;
      gpios_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      check("reset gpios_out", {24'h0, gpios_out}, 32'h00);
      check("reset direction", {24'h0, direction}, 32'h00);
      check("reset read_data", read_data, 32'h0);
      check("reset irq", {31'h0, irq}, 32'd0);

      // Direction and output data
      bus_write(3'd2, 32'h0000_00F0);
      bus_write(3'd1, 32'h0000_00A5);
      check("dir value", {24'h0, direction}, 32'hF0);
      check("data_out value", {24'h0, gpios_out}, 32'hA5);
      bus_read(3'd2, d);
      check("read DIR", d, 32'h0000_00F0);

      // Atomic set/clear; upper write_data bits ignored
      bus_write(3'd1, 32'hFFFF_FF0F);
      check("data_out 0F", {24'h0, gpios_out}, 32'h0F);
      bus_write(3'd6, 32'h0000_0030);
      check("out_set", {24'h0, gpios_out}, 32'h3F);
      bus_write(3'd7, 32'h0000_0003);
      check("out_clr", {24'h0, gpios_out}, 32'h3C);
      bus_read(3'd6, d);
      check("read OUT_SET", d, 32'h0);
      bus_write(3'd2, 32'h0);

      // Synchroniser latency: reads captured at edges 1,2,3 after the pad change
      gpios_in = 8'h5A; address = addr_of(3'd0); read = 1'b1;
      tick();
      check("sync read e1", read_data, 32'h0);
      tick();
      check("sync read e2", read_data, 32'h0);
      tick();
      check("sync read e3", read_data, 32'h5A);
      read = 1'b0;
      tick();

      // Falling edges recorded with POL=0, status sticky but masked by EN=0
      gpios_in = 8'h00;
      repeat (4) tick();
      bus_read(3'd5, d);
      check("falling stat", d, 32'h5A);
      check("masked irq", {31'h0, irq}, 32'd0);
      bus_write(3'd5, 32'hFF);
      bus_read(3'd5, d);
      check("stat cleared", d, 32'h0);

      // Rising edge on pin 3 sets status at edge 3
      bus_write(3'd4, 32'h08);
      bus_write(3'd3, 32'h08);
      gpios_in = 8'h08;
      tick();
      tick();
      check("irq before e3", {31'h0, irq}, 32'd0);
      tick();
      check("irq at e3", {31'h0, irq}, 32'd1);
      bus_read(3'd5, d);
      check("rising stat", d, 32'h08);
      gpios_in = 8'h00;
      repeat (4) tick();
      bus_read(3'd5, d);
      check("falling ignored", d, 32'h08);
      bus_write(3'd5, 32'h08);
      check("irq after w1c", {31'h0, irq}, 32'd0);

      // W1C coinciding with a new event: set wins
      gpios_in = 8'h08;
      tick();
      tick();
      address = addr_of(3'd5); write_data = 32'h08; write = 1'b1;
      tick();
      write = 1'b0;
      check("set wins irq", {31'h0, irq}, 32'd1);
      tick();
      bus_read(3'd5, d);
      check("set wins stat", d, 32'h08);
      bus_write(3'd5, 32'h08);

      // Read and write together: write only, read_data held
      address = addr_of(3'd1); write_data = 32'h77; read = 1'b1; write = 1'b1;
      tick();
      read = 1'b0; write = 1'b0;
      check("rw response", {31'h0, response}, 32'd1);
      check("rw read_data held", read_data, 32'h08);
      check("rw write applied", {24'h0, gpios_out}, 32'h77);
      tick();
      check("rw single response", {31'h0, response}, 32'd0);

      // DATA_IN write acknowledged but ignored
      bus_write(3'd0, 32'hFF);
      bus_read(3'd0, d);
      check("data_in read", d, 32'h08);

      // Output pins record no events
      bus_write(3'd2, 32'h08);
      gpios_in = 8'h00;
      repeat (4) tick();
      gpios_in = 8'h08;
      repeat (4) tick();
      bus_read(3'd5, d);
      check("output pin masked", d, 32'h0);
      bus_write(3'd2, 32'hF0);
      bus_read(3'd2, d);
      check("dir F0", d, 32'hF0);

      // Asynchronous reset in the middle of a DATA_OUT write
      address = addr_of(3'd1); write_data = 32'hFF; write = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async gpios_out", {24'h0, gpios_out}, 32'h00);
      check("async direction", {24'h0, direction}, 32'h00);
      check("async read_data", read_data, 32'h0);
      check("async response", {31'h0, response}, 32'd0);
      tick();
      write = 1'b0;
      reset = 1'b0;
      tick();
      check("no resp after reset", {31'h0, response}, 32'd0);
      check("write dropped", {24'h0, gpios_out}, 32'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
